// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: in1 - in2 - bin, one bit per clock LSB first, through one
// full-subtractor cell and a borrow flop; start/ready operand handshake, valid/ready result.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_subtractor: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic             sign_a;
  logic             sign_b;
  logic [CW-1:0]    cnt;
  logic             bout_r;
  logic             overflow_r;
  logic             zero_r;

  logic             d;
  logic             borrow_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    d           = a[0] ^ b[0] ^ borrow;
    borrow_next = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow);
    res_next    = {d, res[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      res        <= '0;
      borrow     <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      cnt        <= '0;
      bout_r     <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SHIFT;
            a          <= in1;
            b          <= in2;
            borrow     <= bin;
            sign_a     <= in1[WIDTH-1];
            sign_b     <= in2[WIDTH-1];
            cnt        <= '0;
            res        <= '0;
            bout_r     <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
          end
        end
        SHIFT: begin
          a      <= a >> 1;
          b      <= b >> 1;
          borrow <= borrow_next;
          res    <= res_next;
          cnt    <= cnt + CW'(1);
          // Flags are resolved on the last bit so they are registered on entry to DONE.
          if (cnt == CW'(WIDTH - 1)) begin
            state      <= DONE;
            bout_r     <= borrow_next;
            overflow_r <= (sign_a != sign_b) && (d != sign_a);
            zero_r     <= (res_next == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);
  assign diff      = res;
  assign bout      = bout_r;
  assign overflow  = overflow_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed table-driven bench for serial_subtractor (WIDTH=4) plus handshake/reset sequences.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         resetn;
  logic         start;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         bin;
  logic         in_ready;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;
  logic         zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs[10];

  serial_subtractor #(.WIDTH(W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .bin       (bin),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Presents operands for one accept edge; returns at the negedge after it.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    start = 1'b1;
    in1   = x;
    in2   = y;
    bin   = c;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts rising edges until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, out_valid, 1'b0);
    check({tag, ".in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int    n;
    string t;

    vecs[0] = '{4'b1101, 4'b1010, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b1010, 4'b1011, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{4'b1111, 4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{4'b0110, 4'b1101, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{4'b1001, 4'b0001, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0};

    resetn    = 1'b0;
    start     = 1'b0;
    in1       = '0;
    in2       = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.diff", diff, '0);
    check("rst.bout", bout, 1'b0);
    check("rst.overflow", overflow, 1'b0);
    check("rst.zero", zero, 1'b0);
    resetn = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst.in_ready", in_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      t = $sformatf("vec%0d", i);
      issue(vecs[i].in1, vecs[i].in2, vecs[i].bin);
      check({t, ".busy"}, busy, 1'b1);
      check({t, ".in_ready_low"}, in_ready, 1'b0);
      check({t, ".diff_cleared"}, diff, '0);
      wait_valid(n);
      check({t, ".latency"}, n, W);
      check({t, ".diff"}, diff, vecs[i].diff);
      check({t, ".bout"}, bout, vecs[i].bout);
      check({t, ".overflow"}, overflow, vecs[i].ovf);
      check({t, ".zero"}, zero, vecs[i].zero);
      release_result(t);
      check({t, ".diff_hold"}, diff, vecs[i].diff);
    end

    // start re-asserted during SHIFT must be ignored; then hold off the consumer.
    issue(vecs[0].in1, vecs[0].in2, vecs[0].bin);
    start = 1'b1;
    in1   = 4'b0001;
    in2   = 4'b0000;
    bin   = 1'b0;
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
    end
    start = 1'b0;
    wait_valid(n);
    check("ign.latency", n, W - 2);
    check("ign.diff", diff, vecs[0].diff);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      @(negedge clock);
      check($sformatf("bp%0d.out_valid", k), out_valid, 1'b1);
      check($sformatf("bp%0d.diff", k), diff, vecs[0].diff);
    end
    release_result("bp");

    // Reset in the middle of SHIFT discards the operation.
    issue(4'b0111, 4'b0010, 1'b0);
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    check("mrst.in_ready", in_ready, 1'b1);
    check("mrst.out_valid", out_valid, 1'b0);
    check("mrst.busy", busy, 1'b0);
    check("mrst.diff", diff, '0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (out_valid) n++;
    end
    check("mrst.no_result", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
